// File: rtl/vector_pair_loader_if.sv
// Element-pair stream in, packed A/B vector out, with valid/ready and valid/ack.
// master drives pairs and acks; slave is the loader.
interface vector_pair_loader_if #(
   parameter int N = 3,
   parameter int W = 8
);
   localparam int CW = $clog2(N + 1);

   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    a_elem;
   logic [W-1:0]    b_elem;
   logic            in_last;
   logic [N*W-1:0]  A;
   logic [N*W-1:0]  B;
   logic            vec_valid;
   logic            vec_ack;
   logic [CW-1:0]   count;

   modport master (
      output in_valid,
      output a_elem,
      output b_elem,
      output in_last,
      output vec_ack,
      input  in_ready,
      input  A,
      input  B,
      input  vec_valid,
      input  count
   );

   modport slave (
      input  in_valid,
      input  a_elem,
      input  b_elem,
      input  in_last,
      input  vec_ack,
      output in_ready,
      output A,
      output B,
      output vec_valid,
      output count
   );
endinterface

// File: rtl/vector_pair_loader.sv
// Packs N (a,b) element pairs into flat A/B vectors for the dot-product stage.
// Short vectors are zero-padded; the packed pair is held until acknowledged.
module vector_pair_loader #(
   parameter int N = 3,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   vector_pair_loader_if.slave  bus
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [N*W-1:0]  a_q, a_d;
   logic [N*W-1:0]  b_q, b_d;
   logic [CW-1:0]   count_q, count_d;
   logic            vec_valid_q, vec_valid_d;
   logic            accept;
   logic            close;

   assign bus.in_ready  = (state_q == FILL) & ~rst;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.vec_valid = vec_valid_q;
   assign bus.count     = count_q;

   assign accept = bus.in_valid & bus.in_ready;
   assign close  = bus.in_last | (count_q == CW'(N - 1));

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      count_d     = count_q;
      vec_valid_d = vec_valid_q;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               // Write slot k; on an early last, clear the slots after it.
               for (int i = 0; i < N; i++) begin
                  if (CW'(i) == count_q) begin
                     a_d[N*W-1-i*W -: W] = bus.a_elem;
                     b_d[N*W-1-i*W -: W] = bus.b_elem;
                  end else if (bus.in_last && (CW'(i) > count_q)) begin
                     a_d[N*W-1-i*W -: W] = '0;
                     b_d[N*W-1-i*W -: W] = '0;
                  end
               end
               count_d = count_q + CW'(1);
               if (close) begin
                  state_d     = HOLD;
                  vec_valid_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (bus.vec_ack) begin
               state_d     = FILL;
               vec_valid_d = 1'b0;
               count_d     = '0;
            end
         end
         default: begin
            state_d     = FILL;
            vec_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         a_q         <= '0;
         b_q         <= '0;
         count_q     <= '0;
         vec_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         count_q     <= count_d;
         vec_valid_q <= vec_valid_d;
      end
   end
endmodule

// File: tb/tb_vector_pair_loader.sv
// Bench for vector_pair_loader: directed scenarios plus a random run
// compared against an array-based model of the loader.
module tb_vector_pair_loader;
   localparam int N  = 3;
   localparam int W  = 8;
   localparam int CW = $clog2(N + 1);

   logic clk;
   logic rst;

   vector_pair_loader_if #(.N(N), .W(W)) vif ();

   vector_pair_loader #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model: element arrays, fill count, holding flag
   int m_a [N];
   int m_b [N];
   int m_cnt;
   bit m_hold;

   function automatic logic [N*W-1:0] pack(input int e [N]);
      logic [N*W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         v = (v << W) | (N*W)'(e[i] & ((1 << W) - 1));
      return v;
   endfunction

   function automatic int dot(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
      int s;
      s = 0;
      for (int i = 0; i < N; i++)
         s += int'(a[i*W +: W]) * int'(b[i*W +: W]);
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_a[i] = 0;
         m_b[i] = 0;
      end
      m_cnt  = 0;
      m_hold = 0;
   endtask

   task automatic model_step(input bit v, input int a, input int b,
                             input bit last, input bit ack);
      if (!m_hold) begin
         if (v) begin
            m_a[m_cnt] = a;
            m_b[m_cnt] = b;
            m_cnt++;
            if (last || m_cnt == N) begin
               for (int i = m_cnt; i < N; i++) begin
                  m_a[i] = 0;
                  m_b[i] = 0;
               end
               m_hold = 1;
            end
         end
      end else if (ack) begin
         m_hold = 0;
         m_cnt  = 0;
      end
   endtask

   task automatic drive(input bit v, input int a, input int b,
                        input bit last, input bit ack);
      vif.in_valid = v;
      vif.a_elem   = W'(a);
      vif.b_elem   = W'(b);
      vif.in_last  = last;
      vif.vec_ack  = ack;
   endtask

   task automatic tick();
      model_step(vif.in_valid, int'(vif.a_elem), int'(vif.b_elem),
                 vif.in_last, vif.vec_ack);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic load3(input int a0, input int a1, input int a2);
      drive(1, a0, a0, 0, 0); tick();
      drive(1, a1, a1, 0, 0); tick();
      drive(1, a2, a2, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0);
      rst = 1'b1;
      model_reset();
      #3;
      n_checks++;
      if ({vif.A, vif.B, vif.count, vif.vec_valid, vif.in_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_vals got A=%h B=%h cnt=%0d vv=%b rdy=%b want all 0",
                  vif.A, vif.B, vif.count, vif.vec_valid, vif.in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (vif.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got %b want 1", vif.in_ready);
      end
   endtask

   task automatic test_full_load();
      do_reset();
      drive(1, 1, 1, 0, 0); tick();
      drive(1, 2, 2, 0, 0); tick();
      n_checks++;
      if (vif.vec_valid !== 1'b0 || vif.count !== CW'(2)) begin
         n_fail++;
         $display("FAIL full_mid got vv=%b cnt=%0d want vv=0 cnt=2",
                  vif.vec_valid, vif.count);
      end
      drive(1, 3, 3, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (vif.A !== 24'h010203 || vif.B !== 24'h010203 ||
          vif.count !== CW'(3) || vif.vec_valid !== 1'b1 || vif.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_vec got A=%h B=%h cnt=%0d vv=%b rdy=%b want 010203 010203 3 1 0",
                  vif.A, vif.B, vif.count, vif.vec_valid, vif.in_ready);
      end
      n_checks++;
      if (dot(vif.A, vif.B) != 14) begin
         n_fail++;
         $display("FAIL full_dot got %0d want 14", dot(vif.A, vif.B));
      end
   endtask

   task automatic test_short();
      do_reset();
      load3(8, 8, 8);
      drive(0, 0, 0, 0, 1); tick();
      drive(1, 10, 10, 0, 0); tick();
      drive(1, 5, 5, 1, 0); tick();
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (vif.A !== 24'h0A0500 || vif.B !== 24'h0A0500 ||
          vif.count !== CW'(2) || vif.vec_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL short_vec got A=%h B=%h cnt=%0d vv=%b want 0a0500 0a0500 2 1",
                  vif.A, vif.B, vif.count, vif.vec_valid);
      end
      n_checks++;
      if (dot(vif.A, vif.B) != 125) begin
         n_fail++;
         $display("FAIL short_dot got %0d want 125", dot(vif.A, vif.B));
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      load3(1, 2, 3);
      for (int c = 0; c < 5; c++) begin
         drive(1, 9, 9, 0, 0); tick();
         n_checks++;
         if (vif.in_ready !== 1'b0 || vif.A !== 24'h010203 ||
             vif.B !== 24'h010203 || vif.vec_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold[%0d] got rdy=%b A=%h B=%h vv=%b want 0 010203 010203 1",
                     c, vif.in_ready, vif.A, vif.B, vif.vec_valid);
         end
      end
      drive(1, 9, 9, 0, 1); tick();
      n_checks++;
      if (vif.vec_valid !== 1'b0 || vif.in_ready !== 1'b1 ||
          vif.count !== CW'(0) || vif.A !== 24'h010203) begin
         n_fail++;
         $display("FAIL bp_ack got vv=%b rdy=%b cnt=%0d A=%h want 0 1 0 010203",
                  vif.vec_valid, vif.in_ready, vif.count, vif.A);
      end
      drive(1, 9, 9, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (vif.A !== 24'h090203 || vif.B !== 24'h090203 || vif.count !== CW'(1)) begin
         n_fail++;
         $display("FAIL bp_slot0 got A=%h B=%h cnt=%0d want 090203 090203 1",
                  vif.A, vif.B, vif.count);
      end
   endtask

   task automatic test_sparse();
      bit vpat [6] = '{1, 0, 0, 1, 0, 1};
      int vals [3] = '{10, 5, 2};
      int k;
      int accepts;
      do_reset();
      k = 0;
      accepts = 0;
      for (int c = 0; c < 6; c++) begin
         if (vpat[c]) drive(1, vals[k], vals[k], 0, 0);
         else drive(0, 99, 99, 0, 0);
         if (vpat[c] && vif.in_ready) accepts++;
         if (vpat[c]) k++;
         tick();
      end
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (accepts != 3 || vif.count !== CW'(3)) begin
         n_fail++;
         $display("FAIL sparse_cnt got accepts=%0d cnt=%0d want 3 3", accepts, vif.count);
      end
      n_checks++;
      if (vif.A !== 24'h0A0502 || vif.B !== 24'h0A0502 || vif.vec_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sparse_vec got A=%h B=%h vv=%b want 0a0502 0a0502 1",
                  vif.A, vif.B, vif.vec_valid);
      end
      n_checks++;
      if (dot(vif.A, vif.B) != 129) begin
         n_fail++;
         $display("FAIL sparse_dot got %0d want 129", dot(vif.A, vif.B));
      end
   endtask

   task automatic test_reset_midfill();
      do_reset();
      drive(1, 7, 7, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (vif.count !== CW'(1) || vif.A !== 24'h070000) begin
         n_fail++;
         $display("FAIL rmid_pre got cnt=%0d A=%h want 1 070000", vif.count, vif.A);
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({vif.A, vif.B, vif.count, vif.vec_valid, vif.in_ready} !== '0) begin
         n_fail++;
         $display("FAIL rmid_clear got A=%h B=%h cnt=%0d vv=%b rdy=%b want all 0",
                  vif.A, vif.B, vif.count, vif.vec_valid, vif.in_ready);
      end
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      load3(1, 2, 3);
      n_checks++;
      if (vif.A !== 24'h010203 || vif.count !== CW'(3) || vif.vec_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_reload got A=%h cnt=%0d vv=%b want 010203 3 1",
                  vif.A, vif.count, vif.vec_valid);
      end
   endtask

   task automatic test_spurious_ack();
      do_reset();
      drive(1, 4, 4, 0, 0); tick();
      drive(0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (vif.count !== CW'(1) || vif.vec_valid !== 1'b0 ||
          vif.in_ready !== 1'b1 || vif.A !== 24'h040000) begin
         n_fail++;
         $display("FAIL sack_nochg got cnt=%0d vv=%b rdy=%b A=%h want 1 0 1 040000",
                  vif.count, vif.vec_valid, vif.in_ready, vif.A);
      end
      drive(1, 5, 5, 0, 0); tick();
      drive(1, 6, 6, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (vif.A !== 24'h040506 || vif.B !== 24'h040506 || vif.vec_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sack_fill got A=%h B=%h vv=%b want 040506 040506 1",
                  vif.A, vif.B, vif.vec_valid);
      end
   endtask

   task automatic test_random();
      logic [N*W-1:0] ea, eb;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(1, 0) == 1, int'($urandom_range(255, 0)),
               int'($urandom_range(255, 0)), $urandom_range(3, 0) == 0,
               $urandom_range(2, 0) == 0);
         tick();
         ea = pack(m_a);
         eb = pack(m_b);
         n_checks++;
         if (vif.A !== ea || vif.B !== eb || vif.count !== CW'(m_cnt) ||
             vif.vec_valid !== m_hold || vif.in_ready !== !m_hold) begin
            n_fail++;
            $display("FAIL rand[%0d] got A=%h B=%h cnt=%0d vv=%b rdy=%b want %h %h %0d %b %b",
                     c, vif.A, vif.B, vif.count, vif.vec_valid, vif.in_ready,
                     ea, eb, m_cnt, m_hold, !m_hold);
         end
      end
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      test_reset();
      test_full_load();
      test_short();
      test_backpressure();
      test_sparse();
      test_reset_midfill();
      test_spurious_ack();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
